btn_input_ctrl: RTL and testbench
=================================

# btn_input_ctrl

Parametrised multi-channel front-panel button processor, the successor to the single-channel debouncer used for the volume buttons. Each channel gets a synchroniser, a debouncer, one-cycle press and release strobes, and hold-to-repeat strobes. Each channel also has a sticky event flag, so software polling the PIO through the system interconnect cannot miss a short press. It runs in the capture pixel-clock domain and feeds the `pio_0_ctrl_in` word.

## Interface
- `NUM_BTNS`, 2: number of independent channels (1..16).
- `ACTIVE_LOW`, 1: 1 = raw pin low means pressed; 0 = raw pin high means pressed.
- `MIN_PULSE_WIDTH`, 25000: cycles a synchronised level must persist before it is accepted (≥1).
- `REPEAT_DELAY`, 13500000: cycles from the press strobe to the first repeat strobe; 0 disables repeat.
- `REPEAT_RATE`, 2700000: cycles between subsequent repeat strobes (≥1).
- `i_clk`  in  1: sole clock (capture pixel clock).
- `reset_n`  in  1: asynchronous, active-low reset.
- `i_btn`  in  NUM_BTNS: raw button pins, asynchronous to `i_clk`.
- `i_evt_clr`  in  NUM_BTNS: write-one-to-clear for `o_evt`; a per-bit single-cycle pulse.
- `o_btn`  out  NUM_BTNS: debounced level, 1 = pressed.
- `o_press`  out  NUM_BTNS: one-cycle strobe on a debounced press.
- `o_release`  out  NUM_BTNS: one-cycle strobe on a debounced release.
- `o_repeat`  out  NUM_BTNS: one-cycle auto-repeat strobe while held.
- `o_evt`  out  NUM_BTNS: sticky flag, set by press or repeat.
- `o_evt_any`  out  1: OR of all `o_evt` bits.

## Operation
- Channels are fully independent. Everything below applies per channel i.
- **Polarity:** the raw pin is XORed with `ACTIVE_LOW`, giving 1 = pressed. This happens before the synchroniser.
- **Synchroniser:** 2 flops; reset value 0 (released).
- **Debounce:**
  - Counter width is $clog2(MIN_PULSE_WIDTH+1).
  - When sync == stable: counter is cleared.
  - When sync != stable and counter < MIN_PULSE_WIDTH-1: counter increments.
  - When sync != stable and counter == MIN_PULSE_WIDTH-1: stable <= sync and counter <= 0.
  - A glitch shorter than MIN_PULSE_WIDTH cycles never changes `o_btn`.
  - `o_btn` = stable.
- **Strobes:**
  - `o_press` is registered and high exactly in the first cycle `o_btn` reads 1.
  - `o_release` is high exactly in the first cycle `o_btn` reads 0.
- **Repeat FSM**, states IDLE, DELAY, REPEAT. The repeat counter width is $clog2(max(REPEAT_DELAY, REPEAT_RATE)+1).
  - IDLE -> DELAY on the stable 0->1 transition; counter <= 0.
  - DELAY: counter increments each cycle. When counter == REPEAT_DELAY-1, the FSM pulses `o_repeat`, clears the counter and enters REPEAT.
  - REPEAT: counter increments each cycle. When counter == REPEAT_RATE-1, the FSM pulses `o_repeat`, clears the counter and stays in REPEAT.
  - Any state -> IDLE on the stable 1->0 transition, with no repeat in that cycle. Release has priority over a coincident terminal count.
  - If REPEAT_DELAY == 0, the FSM stays in IDLE permanently and `o_repeat` is always 0.
- **Sticky event:**
  - Set when `o_press` or `o_repeat` is high in this cycle.
  - Cleared on `i_evt_clr` = 1 when there is no coincident set. Set wins over clear in the same cycle.
  - Release does not set the flag.
- **Reset:** all outputs, synchronisers, counters and the FSM go to 0 / IDLE. A button held through reset is seen as a fresh press MIN_PULSE_WIDTH+2 cycles after deassertion.

## Timing
- Raw pin edge (stable thereafter) -> `o_btn` change: 2 + MIN_PULSE_WIDTH cycles (2 synchroniser cycles + MIN_PULSE_WIDTH counting cycles).
- `o_press` and `o_release` coincide with the `o_btn` change cycle.
- First `o_repeat` comes REPEAT_DELAY cycles after `o_press`. Subsequent repeats are every REPEAT_RATE cycles.
- `o_evt` rises 1 cycle after the press or repeat strobe and falls 1 cycle after `i_evt_clr`.
- `o_evt_any` is combinational from the `o_evt` registers (0 extra cycles).
- `reset_n` assertion clears all outputs immediately (asynchronous). Deassertion should be synchronous to `i_clk` at the integration level.
- All outputs are registered except `o_evt_any`. No combinational path from `i_btn` to any output.

## Test plan
Unless stated otherwise, use NUM_BTNS=2, ACTIVE_LOW=1, MIN_PULSE_WIDTH=4, REPEAT_DELAY=10, REPEAT_RATE=3.

1. **Reset:** `i_btn`=2'b11 with reset_n=0 -> all outputs 0; after reset_n=1, no strobes for 100 cycles.
2. **Press and release:** ch0 driven low at cycle T -> `o_btn[0]`=1 and `o_press[0]`=1 at T+6 for 1 cycle; ch1 unaffected. Driven high at T+50 -> `o_release[0]` at T+56, and `o_evt` is not set by the release.
3. **Glitch rejection:** ch0 low for 3 cycles, then high -> `o_btn`, `o_press` and `o_evt` all stay 0. Then low for 4 cycles -> press is accepted.
4. **Auto-repeat:** hold ch1 for 30 cycles after the press strobe at P -> `o_repeat[1]` at P+10, P+13, P+16 … P+28. Release -> no further repeats, FSM back in IDLE. Same stimulus with REPEAT_DELAY=0 -> `o_repeat` never asserts.
5. **Sticky and clear race:**
   - Press ch0 -> `o_evt[0]`=1 and `o_evt_any`=1.
   - Pulse `i_evt_clr[0]` in the same cycle as a repeat strobe -> `o_evt[0]` stays 1.
   - Pulse `i_evt_clr[0]` alone -> `o_evt[0]`=0 next cycle and `o_evt_any`=0.
6. **Mid-operation reset:** assert reset_n=0 while ch0 is in REPEAT with the counter at 2 -> outputs 0 immediately. Deassert with the button still held -> new `o_press` 6 cycles later, and the first repeat comes REPEAT_DELAY cycles after that.

Source files
------------

// File: rtl/btn_input_ctrl.sv
// Multi-channel front-panel button processor: synchroniser, debouncer, press/release
// strobes, hold-to-repeat strobes and a sticky software-visible event flag per channel.
module btn_input_ctrl #(
  parameter int unsigned NUM_BTNS        = 2,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned MIN_PULSE_WIDTH = 25000,
  parameter int unsigned REPEAT_DELAY    = 13500000,
  parameter int unsigned REPEAT_RATE     = 2700000
) (
  input  logic                i_clk,
  input  logic                reset_n,
  input  logic [NUM_BTNS-1:0] i_btn,
  input  logic [NUM_BTNS-1:0] i_evt_clr,
  output logic [NUM_BTNS-1:0] o_btn,
  output logic [NUM_BTNS-1:0] o_press,
  output logic [NUM_BTNS-1:0] o_release,
  output logic [NUM_BTNS-1:0] o_repeat,
  output logic [NUM_BTNS-1:0] o_evt,
  output logic                o_evt_any
);

  localparam int unsigned DB_W    = $clog2(MIN_PULSE_WIDTH + 1);
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(MIN_PULSE_WIDTH - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);
  localparam logic             POLARITY   = 1'(ACTIVE_LOW);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [DB_W-1:0]  db_cnt;
    logic [RPT_W-1:0] rpt_cnt;
    rpt_state_t       state;
    logic             press_q;
    logic             release_q;
    logic             repeat_q;
    logic             evt_q;
    logic             accept;

    // Synchronised level has disagreed with the stable level for the full window.
    assign accept = (sync2 != stable) && (db_cnt == DB_LAST);

    always_ff @(posedge i_clk or negedge reset_n) begin
      if (!reset_n) begin
        sync1     <= 1'b0;
        sync2     <= 1'b0;
        stable    <= 1'b0;
        db_cnt    <= '0;
        rpt_cnt   <= '0;
        state     <= IDLE;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
        evt_q     <= 1'b0;
      end else begin
        sync1     <= i_btn[i] ^ POLARITY;
        sync2     <= sync1;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;

        if (sync2 == stable) begin
          db_cnt <= '0;
        end else if (accept) begin
          stable    <= sync2;
          db_cnt    <= '0;
          press_q   <= sync2;
          release_q <= !sync2;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end

        // Release always wins over a terminal count landing in the same cycle.
        if (REPEAT_DELAY == 0) begin
          state   <= IDLE;
          rpt_cnt <= '0;
        end else if (accept && !sync2) begin
          state   <= IDLE;
          rpt_cnt <= '0;
        end else begin
          case (state)
            IDLE: begin
              if (accept && sync2) begin
                state   <= DELAY;
                rpt_cnt <= '0;
              end
            end
            DELAY: begin
              if (rpt_cnt == DELAY_LAST) begin
                repeat_q <= 1'b1;
                rpt_cnt  <= '0;
                state    <= REPEAT;
              end else begin
                rpt_cnt <= rpt_cnt + RPT_W'(1);
              end
            end
            REPEAT: begin
              if (rpt_cnt == RATE_LAST) begin
                repeat_q <= 1'b1;
                rpt_cnt  <= '0;
              end else begin
                rpt_cnt <= rpt_cnt + RPT_W'(1);
              end
            end
            default: begin
              state   <= IDLE;
              rpt_cnt <= '0;
            end
          endcase
        end

        // A set in the same cycle as a clear keeps the flag.
        if (press_q || repeat_q) begin
          evt_q <= 1'b1;
        end else if (i_evt_clr[i]) begin
          evt_q <= 1'b0;
        end
      end
    end

    assign o_btn[i]     = stable;
    assign o_press[i]   = press_q;
    assign o_release[i] = release_q;
    assign o_repeat[i]  = repeat_q;
    assign o_evt[i]     = evt_q;
  end

  assign o_evt_any = |o_evt;

endmodule

// File: tb/tb_btn_input_ctrl.sv
// Scoreboard bench for btn_input_ctrl: a history-based reference model predicts each
// cycle's outputs for a repeating instance and a repeat-disabled instance.
module tb_btn_input_ctrl;

  localparam int unsigned NB  = 2;
  localparam int unsigned AL  = 1;
  localparam int unsigned MPW = 4;
  localparam int unsigned RD  = 10;
  localparam int unsigned RR  = 3;

  logic          clk;
  logic          reset_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] evt_clr;

  logic [NB-1:0] btn, press, rel, rpt, evt;
  logic          evt_any;
  logic [NB-1:0] nr_btn, nr_press, nr_rel, nr_rpt, nr_evt;
  logic          nr_evt_any;

  btn_input_ctrl #(
    .NUM_BTNS(NB), .ACTIVE_LOW(AL), .MIN_PULSE_WIDTH(MPW),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .i_clk(clk), .reset_n(reset_n), .i_btn(btn_raw), .i_evt_clr(evt_clr),
    .o_btn(btn), .o_press(press), .o_release(rel), .o_repeat(rpt),
    .o_evt(evt), .o_evt_any(evt_any)
  );

  btn_input_ctrl #(
    .NUM_BTNS(NB), .ACTIVE_LOW(AL), .MIN_PULSE_WIDTH(MPW),
    .REPEAT_DELAY(0), .REPEAT_RATE(RR)
  ) dut_nr (
    .i_clk(clk), .reset_n(reset_n), .i_btn(btn_raw), .i_evt_clr(evt_clr),
    .o_btn(nr_btn), .o_press(nr_press), .o_release(nr_rel), .o_repeat(nr_rpt),
    .o_evt(nr_evt), .o_evt_any(nr_evt_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NB-1:0] btn;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    logic [NB-1:0] rep0;
    logic [NB-1:0] evt0;
    logic [NB-1:0] rep1;
    logic [NB-1:0] evt1;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Reference model state: raw history, last acceptance, press edge, flags.
  logic           pipe1[NB];
  logic           pipe2[NB];
  logic [MPW-1:0] win[NB];
  logic           stb[NB];
  int             last_flip[NB];
  int             pedge[NB];
  logic           prev_press[NB];
  logic           prev_rep[2][NB];
  logic           mevt[2][NB];
  int             k;

  task automatic model_reset();
    for (int c = 0; c < NB; c++) begin
      pipe1[c] = 1'b0; pipe2[c] = 1'b0; win[c] = '0; stb[c] = 1'b0;
      last_flip[c] = -1000; pedge[c] = 0; prev_press[c] = 1'b0;
      for (int r = 0; r < 2; r++) begin
        prev_rep[r][c] = 1'b0;
        mevt[r][c]     = 1'b0;
      end
    end
    k = 0;
  endtask

  // Predict the outputs after the next rising edge given the inputs presented to it.
  task automatic model_edge(input logic [NB-1:0] raw, input logic [NB-1:0] clr);
    exp_t e;
    e = '0;
    for (int c = 0; c < NB; c++) begin
      logic pr, lvl, flip, held, rep;
      int   d, rdv;
      pr  = raw[c] ^ 1'(AL);
      lvl = pipe2[c];
      pipe2[c] = pipe1[c];
      pipe1[c] = pr;
      win[c] = {win[c][MPW-2:0], lvl};
      flip = ((k - last_flip[c]) >= int'(MPW)) && (win[c] == (stb[c] ? {MPW{1'b0}} : {MPW{1'b1}}));
      held = stb[c] && !flip;
      d    = k - pedge[c];
      for (int r = 0; r < 2; r++) begin
        rdv = (r == 0) ? int'(RD) : 0;
        rep = (rdv != 0) && held && (d >= rdv) && (((d - rdv) % int'(RR)) == 0);
        if (prev_press[c] || prev_rep[r][c]) mevt[r][c] = 1'b1;
        else if (clr[c]) mevt[r][c] = 1'b0;
        prev_rep[r][c] = rep;
      end
      prev_press[c] = flip && !stb[c];
      e.press[c] = flip && !stb[c];
      e.rel[c]   = flip && stb[c];
      if (flip) begin
        stb[c] = !stb[c];
        last_flip[c] = k;
        if (stb[c]) pedge[c] = k;
      end
      e.btn[c]  = stb[c];
      e.rep0[c] = prev_rep[0][c];
      e.rep1[c] = prev_rep[1][c];
      e.evt0[c] = mevt[0][c];
      e.evt1[c] = mevt[1][c];
    end
    k++;
    exp_q.push_back(e);
  endtask

  task automatic apply(input logic [NB-1:0] raw, input logic [NB-1:0] clr);
    btn_raw = raw;
    evt_clr = clr;
    model_edge(raw, clr);
  endtask

  task automatic step(input logic [NB-1:0] raw, input logic [NB-1:0] clr);
    @(negedge clk);
    apply(raw, clr);
  endtask

  // Monitor: every edge that has a prediction is compared shortly after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("btn",        32'(btn),        32'(e.btn));
      chk("press",      32'(press),      32'(e.press));
      chk("release",    32'(rel),        32'(e.rel));
      chk("repeat",     32'(rpt),        32'(e.rep0));
      chk("evt",        32'(evt),        32'(e.evt0));
      chk("evt_any",    32'(evt_any),    32'(|e.evt0));
      chk("nr_btn",     32'(nr_btn),     32'(e.btn));
      chk("nr_press",   32'(nr_press),   32'(e.press));
      chk("nr_release", 32'(nr_rel),     32'(e.rel));
      chk("nr_repeat",  32'(nr_rpt),     32'(e.rep1));
      chk("nr_evt",     32'(nr_evt),     32'(e.evt1));
      chk("nr_evt_any", 32'(nr_evt_any), 32'(|e.evt1));
    end
  end

  // Assert reset between edges, confirm outputs drop at once, then release with raw held.
  task automatic rst_seq(input logic [NB-1:0] raw);
    @(negedge clk);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("reset_outputs", 32'({btn, press, rel, rpt, evt, evt_any}), 32'(0));
    chk("reset_outputs_nr", 32'({nr_btn, nr_press, nr_rel, nr_rpt, nr_evt, nr_evt_any}), 32'(0));
    btn_raw = raw;
    evt_clr = '0;
    repeat (3) @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    apply(raw, '0);
  endtask

  // Hold ch0 pressed after its first sample; check latency, repeat spacing and the clear race.
  task automatic measure(input int n);
    int p_at, r1, r2;
    logic [NB-1:0] clr;
    p_at = -1; r1 = -1; r2 = -1;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #2;
      if (press[0] && p_at < 0) p_at = i;
      if (rpt[0]) begin
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
      if (r1 > 0 && i == r1 + 1) chk("evt_kept_on_race", 32'(evt[0]), 32'(1));
      if (r1 > 0 && i == r1 + 2) begin
        chk("evt_cleared", 32'(evt[0]), 32'(0));
        chk("evt_any_cleared", 32'(evt_any), 32'(0));
      end
      clr = '0;
      if (r1 > 0 && (i == r1 || i == r1 + 1)) clr[0] = 1'b1;
      if (i < n) step(2'b10, clr);
    end
    chk("press_latency", 32'(p_at), 32'(MPW + 2));
    chk("first_repeat", 32'(r1), 32'(MPW + 2 + RD));
    chk("second_repeat", 32'(r2), 32'(MPW + 2 + RD + RR));
  endtask

  initial begin
    logic [NB-1:0] lvl;
    logic [NB-1:0] clr;
    int            dur[NB];

    reset_n = 1'b1;
    btn_raw = '1;
    evt_clr = '0;
    model_reset();
    #2;
    rst_seq(2'b11);
    repeat (100) step(2'b11, '0);

    // Press ch0 and hold well into repeat, then reset while in REPEAT with the counter at 2.
    step(2'b10, '0);
    measure(30);
    rst_seq(2'b10);
    measure(30);

    // Release, short glitch, minimal accepted pulse, release again.
    repeat (20) step(2'b11, '0);
    repeat (3)  step(2'b10, '0);
    repeat (15) step(2'b11, '0);
    repeat (4)  step(2'b10, '0);
    repeat (20) step(2'b11, '0);

    // Randomised hold/glitch durations on both channels with random clears.
    lvl = '1;
    for (int c = 0; c < NB; c++) dur[c] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < NB; c++) begin
        if (dur[c] == 0) begin
          lvl[c] = ~lvl[c];
          dur[c] = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 40));
        end
        dur[c]--;
        clr[c] = ($urandom_range(0, 7) == 0);
      end
      if (cyc == 1500) rst_seq(lvl);
      else step(lvl, clr);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
